spine_router: RTL and testbench
===============================

# spine_router

Spine-side switch of the leaf/spine fabric: terminates the spine links driven by the four group leaf routers and forwards each flit to the leaf router of the destination group. Per-leaf input FIFOs absorb bursts. Each output has an independent round-robin arbiter. Outputs are registered and use the valid-only link protocol the leaf routers expect, so `ready` is always 1 and there is no backpressure.

## Interface
- `SPINE_ID`, 1: spine index 1..4; informational only, no effect on routing.
- `DWIDTH`, 16: flit payload width.
- `FIFO_DEPTH`, 8: entries per input FIFO; power of two, ≥2.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `arb_enable`  in  1  when 0, no grants are issued; FIFOs still accept.
- `leafN_in_data`  in  DWIDTH  flit from leaf router N (N=1..4).
- `leafN_in_valid`  in  1  flit present this cycle.
- `leafN_dest_addr`  in  6  destination address; bits [5:4] select the group, [3:0] are the GPU-local part.
- `leafN_out_data`  out  DWIDTH  flit to leaf router N.
- `leafN_out_valid`  out  1  one-cycle qualifier for `leafN_out_data`.
- `leafN_out_dest_addr`  out  6  full address forwarded unchanged.
- `fifo_full`, `fifo_empty`  out  4  per-input FIFO status; bit N-1 = leaf N.
- `overflow`  out  4  sticky per-input flag set when a flit is dropped.
- `drop_count`  out  8  saturating total of dropped flits.
- `busy`  out  1  any FIFO non-empty or any `out_valid` high.

## Operation
- **Input FIFO.** Each input stores `{dest_addr, data}`. A flit is pushed on any cycle with valid high.
- **Full FIFO.** On push to a full FIFO:
  - if the same FIFO pops that cycle, the push is accepted and the count is unchanged;
  - otherwise the flit is dropped, `overflow[N-1]` is set, and `drop_count` increments, saturating at 255.
  - Drops on several ports in one cycle add their number to `drop_count` (still saturating).
- **Routing.** The head flit of input i requests output `dest_addr[5:4]+1`: 00→leaf1, 01→leaf2, 10→leaf3, 11→leaf4. A flit whose destination is its own source leaf is forwarded normally (U-turn allowed).
- **Arbitration.** Each output has a 2-bit round-robin pointer `rr`.
  - Among the inputs requesting that output, the first at or after `rr` (mod 4) wins.
  - After a grant, `rr` becomes winner+1 mod 4. With no grant, `rr` holds.
  - Each input has a single head, so it can be granted by at most one output per cycle. Up to 4 flits move per cycle.
- **Pop and output.** A granted input pops its head. The output registers load `data`/`dest_addr` and set `out_valid=1` for exactly one cycle. Outputs with no grant drive `out_valid=0`, and their data holds its last value.
- **arb_enable=0.** No pops, all `out_valid` are 0, and pointers hold.
- **Head-of-line blocking** is accepted behaviour; there is no bypass.
- **Reset values:** all FIFOs empty; pointers 0; `out_valid`=0; out data/addr=0; `overflow`=0; `drop_count`=0; `fifo_empty`=4'hF; `fifo_full`=0; `busy`=0.

## Timing
- **Push.** A flit with valid sampled at edge E is in the FIFO after E.
  - If the FIFO was empty, the flit is head during cycle E+1, is arbitrated combinationally, and is registered at edge E+1.
  - Minimum latency is 2 cycles: in at cycle 0, `out_valid` in cycle 2.
- **Throughput:** 1 flit per output per cycle.
- **Status.** `fifo_full`/`fifo_empty` reflect the post-edge count. `overflow` and `drop_count` update at the edge of the drop.
- **Reset mid-operation.** `reset` high at an edge clears everything per the reset values. All FIFO contents are discarded, and flits presented during reset are discarded.

## Test plan
- **Single flit.** Reset; leaf1 sends data 16'hA5A5 with dest 6'b10_0011 at cycle 0 → `leaf3_out_valid`=1 in cycle 2 only, data A5A5, addr 6'h23; all other outputs stay 0.
- **Round-robin.** All four leaves continuously target leaf2 (dest[5:4]=01) → `leaf2_out` grants follow sources 1,2,3,4,1,… one per cycle; every FIFO drains in order.
- **Parallel flow.** Leaf i targets leaf (i mod 4)+1, all four simultaneously → four `out_valid` pulses in the same cycle, latency 2.
- **Overflow.** Hold `arb_enable`=0 and push 10 flits on leaf4 → `fifo_full[3]`=1 after 8 flits, `overflow[3]`=1, `drop_count`=2. Release `arb_enable` → exactly 8 flits emerge in order.
- **Push/pop on full.** With a full FIFO that pops and pushes in the same cycle → no drop, `fifo_full` stays 1.
- **Reset mid-stream.** Assert `reset` with 3 flits buffered → the next cycle shows `fifo_empty`=4'hF and `busy`=0, and no buffered flit is ever emitted.

Source files
------------

// File: rtl/spine_router_if.sv
// Spine link bundle: four leaf-side input ports and four leaf-side output ports.
// Link protocol is valid-only: a flit transfers whenever valid is high; there is no ready.
interface spine_router_if #(
   parameter int DWIDTH = 16
);
   logic [DWIDTH-1:0] leaf1_in_data, leaf2_in_data, leaf3_in_data, leaf4_in_data;
   logic              leaf1_in_valid, leaf2_in_valid, leaf3_in_valid, leaf4_in_valid;
   logic [5:0]        leaf1_dest_addr, leaf2_dest_addr, leaf3_dest_addr, leaf4_dest_addr;
   logic [DWIDTH-1:0] leaf1_out_data, leaf2_out_data, leaf3_out_data, leaf4_out_data;
   logic              leaf1_out_valid, leaf2_out_valid, leaf3_out_valid, leaf4_out_valid;
   logic [5:0]        leaf1_out_dest_addr, leaf2_out_dest_addr, leaf3_out_dest_addr, leaf4_out_dest_addr;

   modport master (
      output leaf1_in_data, leaf2_in_data, leaf3_in_data, leaf4_in_data,
      output leaf1_in_valid, leaf2_in_valid, leaf3_in_valid, leaf4_in_valid,
      output leaf1_dest_addr, leaf2_dest_addr, leaf3_dest_addr, leaf4_dest_addr,
      input  leaf1_out_data, leaf2_out_data, leaf3_out_data, leaf4_out_data,
      input  leaf1_out_valid, leaf2_out_valid, leaf3_out_valid, leaf4_out_valid,
      input  leaf1_out_dest_addr, leaf2_out_dest_addr, leaf3_out_dest_addr, leaf4_out_dest_addr
   );

   modport slave (
      input  leaf1_in_data, leaf2_in_data, leaf3_in_data, leaf4_in_data,
      input  leaf1_in_valid, leaf2_in_valid, leaf3_in_valid, leaf4_in_valid,
      input  leaf1_dest_addr, leaf2_dest_addr, leaf3_dest_addr, leaf4_dest_addr,
      output leaf1_out_data, leaf2_out_data, leaf3_out_data, leaf4_out_data,
      output leaf1_out_valid, leaf2_out_valid, leaf3_out_valid, leaf4_out_valid,
      output leaf1_out_dest_addr, leaf2_out_dest_addr, leaf3_out_dest_addr, leaf4_out_dest_addr
   );
endinterface

// File: rtl/spine_router.sv
// Spine switch: four input FIFOs, per-output round-robin arbitration on dest[5:4],
// registered valid-only outputs, overflow/drop accounting.
module spine_router #(
   parameter int SPINE_ID   = 1,
   parameter int DWIDTH     = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       arb_enable,
   spine_router_if.slave bus,
   output logic [3:0] fifo_full,
   output logic [3:0] fifo_empty,
   output logic [3:0] overflow,
   output logic [7:0] drop_count,
   output logic       busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DWIDTH + 6;

   if (SPINE_ID < 1 || SPINE_ID > 4 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $error("spine_router: SPINE_ID must be 1..4 and FIFO_DEPTH a power of two >= 2");
   end

   logic [DWIDTH-1:0] w_in_data [4];
   logic [5:0]        w_in_dest [4];
   logic [3:0]        w_in_valid;

   assign w_in_data[0] = bus.leaf1_in_data;
   assign w_in_data[1] = bus.leaf2_in_data;
   assign w_in_data[2] = bus.leaf3_in_data;
   assign w_in_data[3] = bus.leaf4_in_data;
   assign w_in_dest[0] = bus.leaf1_dest_addr;
   assign w_in_dest[1] = bus.leaf2_dest_addr;
   assign w_in_dest[2] = bus.leaf3_dest_addr;
   assign w_in_dest[3] = bus.leaf4_dest_addr;
   assign w_in_valid   = {bus.leaf4_in_valid, bus.leaf3_in_valid, bus.leaf2_in_valid, bus.leaf1_in_valid};

   // Entry layout: {dest_addr[5:0], data}
   logic [EW-1:0] r_mem [4][FIFO_DEPTH];
   logic [AW-1:0] r_wptr [4];
   logic [AW-1:0] r_rptr [4];
   logic [CW-1:0] r_count [4];
   logic [1:0]    r_rr [4];
   logic [3:0]    r_out_valid;
   logic [EW-1:0] r_out_entry [4];
   logic [3:0]    r_overflow;
   logic [7:0]    r_drop_count;

   logic [EW-1:0] w_head [4];
   logic [1:0]    w_head_grp [4];
   logic [3:0]    w_req;
   logic [3:0]    w_out_grant;
   logic [1:0]    w_out_src [4];
   logic [3:0]    w_pop;
   logic [3:0]    w_full;
   logic [3:0]    w_accept;
   logic [3:0]    w_drop;
   logic [2:0]    w_ndrop;
   logic [8:0]    w_drop_sum;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_head[i]     = r_mem[i][r_rptr[i]];
         w_head_grp[i] = w_head[i][EW-1 -: 2];
         w_req[i]      = arb_enable && (r_count[i] != '0);
         w_full[i]     = (r_count[i] == CW'(FIFO_DEPTH));
      end
   end

   // Each input requests exactly one output, so an input wins at most one grant per cycle.
   always_comb begin
      w_out_grant = '0;
      w_pop       = '0;
      for (int o = 0; o < 4; o++) begin
         w_out_src[o] = '0;
         for (int k = 0; k < 4; k++) begin
            if (!w_out_grant[o] && w_req[r_rr[o] + 2'(k)] && (w_head_grp[r_rr[o] + 2'(k)] == 2'(o))) begin
               w_out_grant[o] = 1'b1;
               w_out_src[o]   = r_rr[o] + 2'(k);
            end
         end
         if (w_out_grant[o]) begin
            w_pop[w_out_src[o]] = 1'b1;
         end
      end
   end

   // A push into a full FIFO survives only when the same FIFO pops this cycle.
   always_comb begin
      w_ndrop = '0;
      for (int i = 0; i < 4; i++) begin
         w_accept[i] = w_in_valid[i] && (!w_full[i] || w_pop[i]);
         w_drop[i]   = w_in_valid[i] && w_full[i] && !w_pop[i];
         w_ndrop     = w_ndrop + {2'b00, w_drop[i]};
      end
      w_drop_sum = {1'b0, r_drop_count} + {6'b0, w_ndrop};
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (!reset && w_accept[i]) begin
            r_mem[i][r_wptr[i]] <= {w_in_dest[i], w_in_data[i]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            r_wptr[i]      <= '0;
            r_rptr[i]      <= '0;
            r_count[i]     <= '0;
            r_rr[i]        <= '0;
            r_out_entry[i] <= '0;
         end
         r_out_valid  <= '0;
         r_overflow   <= '0;
         r_drop_count <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_accept[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
            if (w_pop[i])    r_rptr[i] <= r_rptr[i] + 1'b1;
            r_count[i] <= r_count[i] + CW'(w_accept[i]) - CW'(w_pop[i]);
            if (w_out_grant[i]) begin
               r_out_entry[i] <= w_head[w_out_src[i]];
               r_rr[i]        <= w_out_src[i] + 2'd1;
            end
         end
         r_out_valid  <= w_out_grant;
         r_overflow   <= r_overflow | w_drop;
         r_drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         fifo_empty[i] = (r_count[i] == '0);
      end
   end

   assign fifo_full  = w_full;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;
   assign busy       = (~fifo_empty != 4'b0000) || (r_out_valid != 4'b0000);

   assign bus.leaf1_out_valid     = r_out_valid[0];
   assign bus.leaf2_out_valid     = r_out_valid[1];
   assign bus.leaf3_out_valid     = r_out_valid[2];
   assign bus.leaf4_out_valid     = r_out_valid[3];
   assign bus.leaf1_out_data      = r_out_entry[0][DWIDTH-1:0];
   assign bus.leaf2_out_data      = r_out_entry[1][DWIDTH-1:0];
   assign bus.leaf3_out_data      = r_out_entry[2][DWIDTH-1:0];
   assign bus.leaf4_out_data      = r_out_entry[3][DWIDTH-1:0];
   assign bus.leaf1_out_dest_addr = r_out_entry[0][EW-1:DWIDTH];
   assign bus.leaf2_out_dest_addr = r_out_entry[1][EW-1:DWIDTH];
   assign bus.leaf3_out_dest_addr = r_out_entry[2][EW-1:DWIDTH];
   assign bus.leaf4_out_dest_addr = r_out_entry[3][EW-1:DWIDTH];
endmodule

// File: tb/tb_spine_router.sv
// Directed bench for spine_router: latency, round-robin order, parallel flow,
// overflow/drop accounting, push/pop on full, and reset with buffered flits.
module tb_spine_router;
   logic       clk = 1'b0;
   logic       reset;
   logic       arb_enable;
   logic [3:0] fifo_full, fifo_empty, overflow;
   logic [7:0] drop_count;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] exp_q[$];

   spine_router_if #(.DWIDTH(16)) bus ();

   spine_router #(.SPINE_ID(1), .DWIDTH(16), .FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .arb_enable (arb_enable),
      .bus        (bus),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .overflow   (overflow),
      .drop_count (drop_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int n, input logic v, input logic [5:0] a, input logic [15:0] d);
      case (n)
         1: begin bus.leaf1_in_valid = v; bus.leaf1_dest_addr = a; bus.leaf1_in_data = d; end
         2: begin bus.leaf2_in_valid = v; bus.leaf2_dest_addr = a; bus.leaf2_in_data = d; end
         3: begin bus.leaf3_in_valid = v; bus.leaf3_dest_addr = a; bus.leaf3_in_data = d; end
         default: begin bus.leaf4_in_valid = v; bus.leaf4_dest_addr = a; bus.leaf4_in_data = d; end
      endcase
   endtask

   task automatic idle_all();
      for (int n = 1; n <= 4; n++) drive(n, 1'b0, 6'h00, 16'h0000);
   endtask

   function automatic logic [3:0] ovec();
      return {bus.leaf4_out_valid, bus.leaf3_out_valid, bus.leaf2_out_valid, bus.leaf1_out_valid};
   endfunction

   function automatic logic [15:0] odata(input int n);
      case (n)
         1: return bus.leaf1_out_data;
         2: return bus.leaf2_out_data;
         3: return bus.leaf3_out_data;
         default: return bus.leaf4_out_data;
      endcase
   endfunction

   function automatic logic [5:0] oaddr(input int n);
      case (n)
         1: return bus.leaf1_out_dest_addr;
         2: return bus.leaf2_out_dest_addr;
         3: return bus.leaf3_out_dest_addr;
         default: return bus.leaf4_out_dest_addr;
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      arb_enable = 1'b1;
      idle_all();
      step();
      step();
      reset = 1'b0;

      // reset state
      check("rst_valid", ovec(), 4'h0);
      check("rst_empty", fifo_empty, 4'hF);
      check("rst_full", fifo_full, 4'h0);
      check("rst_overflow", overflow, 4'h0);
      check("rst_drops", drop_count, 8'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_data3", odata(3), 16'h0000);

      // single flit leaf1 -> group 10 -> leaf3, out_valid in cycle 2
      drive(1, 1'b1, 6'h23, 16'hA5A5);
      step();
      idle_all();
      check("sf_c1_valid", ovec(), 4'h0);
      check("sf_c1_empty", fifo_empty, 4'hE);
      check("sf_c1_busy", busy, 1'b1);
      step();
      check("sf_c2_valid", ovec(), 4'b0100);
      check("sf_c2_data", odata(3), 16'hA5A5);
      check("sf_c2_addr", oaddr(3), 6'h23);
      step();
      check("sf_c3_valid", ovec(), 4'h0);
      check("sf_c3_hold", odata(3), 16'hA5A5);
      check("sf_c3_busy", busy, 1'b0);

      // round-robin: two flits from every leaf to leaf2
      exp_q = '{16'h0101, 16'h0201, 16'h0301, 16'h0401, 16'h0102, 16'h0202, 16'h0302, 16'h0402};
      for (int n = 1; n <= 4; n++) drive(n, 1'b1, 6'(16 + n), 16'(n * 256 + 1));
      step();
      for (int n = 1; n <= 4; n++) drive(n, 1'b1, 6'(16 + n), 16'(n * 256 + 2));
      step();
      idle_all();
      for (int k = 0; k < 8; k++) begin
         check("rr_valid", ovec(), 4'b0010);
         check("rr_data", odata(2), exp_q.pop_front());
         step();
      end
      check("rr_done_valid", ovec(), 4'h0);
      check("rr_done_empty", fifo_empty, 4'hF);

      // parallel: leaf i -> leaf (i mod 4)+1
      drive(1, 1'b1, 6'h11, 16'hC001);
      drive(2, 1'b1, 6'h22, 16'hC002);
      drive(3, 1'b1, 6'h33, 16'hC003);
      drive(4, 1'b1, 6'h04, 16'hC004);
      step();
      idle_all();
      check("par_c1_valid", ovec(), 4'h0);
      step();
      check("par_c2_valid", ovec(), 4'hF);
      check("par_l1_data", odata(1), 16'hC004);
      check("par_l1_addr", oaddr(1), 6'h04);
      check("par_l2_data", odata(2), 16'hC001);
      check("par_l2_addr", oaddr(2), 6'h11);
      check("par_l3_data", odata(3), 16'hC002);
      check("par_l4_data", odata(4), 16'hC003);
      check("par_l4_addr", oaddr(4), 6'h33);
      step();
      check("par_c3_valid", ovec(), 4'h0);

      // overflow: 10 pushes on leaf4 with arbitration held off
      arb_enable = 1'b0;
      for (int k = 0; k < 10; k++) begin
         drive(4, 1'b1, 6'h05, 16'(16'hD000 + k));
         step();
         check("ovf_no_out", ovec(), 4'h0);
         if (k == 7) begin
            check("ovf_full8", fifo_full, 4'h8);
            check("ovf_drop8", drop_count, 8'd0);
            check("ovf_flag8", overflow, 4'h0);
         end
      end
      idle_all();
      check("ovf_flag", overflow, 4'h8);
      check("ovf_drops", drop_count, 8'd2);
      check("ovf_full", fifo_full, 4'h8);

      // push and pop on the full FIFO in the same cycle
      arb_enable = 1'b1;
      drive(4, 1'b1, 6'h05, 16'hD0FF);
      step();
      idle_all();
      check("pp_full", fifo_full, 4'h8);
      check("pp_drops", drop_count, 8'd2);
      check("pp_valid", ovec(), 4'b0001);
      check("pp_data", odata(1), 16'hD000);
      exp_q = '{16'hD001, 16'hD002, 16'hD003, 16'hD004, 16'hD005, 16'hD006, 16'hD007, 16'hD0FF};
      for (int k = 0; k < 8; k++) begin
         step();
         check("drain_valid", ovec(), 4'b0001);
         check("drain_data", odata(1), exp_q.pop_front());
      end
      step();
      check("drain_done_valid", ovec(), 4'h0);
      check("drain_done_empty", fifo_empty, 4'hF);
      check("drain_ovf_sticky", overflow, 4'h8);

      // multi-port drops in one cycle, then saturation
      arb_enable = 1'b0;
      for (int n = 1; n <= 3; n++) drive(n, 1'b1, 6'h00, 16'h1111);
      for (int k = 0; k < 8; k++) step();
      check("multi_full", fifo_full, 4'h7);
      step();
      check("multi_drops", drop_count, 8'd5);
      check("multi_flags", overflow, 4'hF);
      drive(4, 1'b1, 6'h00, 16'h4444);
      for (int k = 0; k < 70; k++) step();
      check("sat_drops", drop_count, 8'd255);
      check("sat_full", fifo_full, 4'hF);

      // reset with buffered flits and inputs still valid
      arb_enable = 1'b1;
      reset = 1'b1;
      step();
      check("mrst_empty", fifo_empty, 4'hF);
      check("mrst_busy", busy, 1'b0);
      check("mrst_drops", drop_count, 8'd0);
      check("mrst_flags", overflow, 4'h0);
      check("mrst_valid", ovec(), 4'h0);
      reset = 1'b0;
      idle_all();
      for (int k = 0; k < 4; k++) begin
         step();
         check("mrst_no_out", ovec(), 4'h0);
         check("mrst_stay_empty", fifo_empty, 4'hF);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
